assist_mode_sel: RTL and testbench
==================================

ASSIST_MODE_SEL -- requirements
Module: assist_mode_sel

Interface
REQ-001 SHALL have parameter LOCKOUT_CYC, default 1_000_000, meaning clocks after an accepted press during which further presses are ignored (legal range 1..2^24-1).
REQ-002 SHALL have parameter IDLE_CYC, default 250_000_000, meaning inactivity clocks before auto-off (legal range 2..2^28-1; used only with AUTO_OFF_EN).
REQ-003 SHALL have ports: clk  input  1  system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 released  input  1  one-clock pulse, push button released (synchronous to clk, already synchronized upstream).
REQ-006 pedaling  input  1  rider pedaling activity, level, synchronous.
REQ-007 mode  output  2  assist mode: 0=OFF, 1=LOW, 2=MED, 3=HIGH.
REQ-008 scale  output  3  torque scale factor for the assist datapath.
REQ-009 led  output  3  bar-graph drive, thermometer coded.
REQ-010 mode_chg  output  1  one-clock pulse on every mode change.
REQ-011 busy  output  1  high while the lockout counter runs.

Function
REQ-012 SHALL implement a 4-state FSM: OFF->LOW->MED->HIGH->OFF, advancing one state per accepted press.
REQ-013 Accepted press: released==1 while busy==0; any other released pulse SHALL be ignored with no state change.
REQ-014 mode SHALL update on the clk edge that samples the accepted press (1-cycle latency from released to new mode).
REQ-015 On an accepted press, busy SHALL go high on the same edge and stay high exactly LOCKOUT_CYC cycles, then drop.
REQ-016 A release arriving in the cycle busy deasserts SHALL be accepted (busy is evaluated as the registered value).
REQ-017 scale SHALL be registered and decode as: OFF 3'd0, LOW 3'd3, MED 3'd5, HIGH 3'd7.
REQ-018 led SHALL be registered and decode as: OFF 3'b000, LOW 3'b001, MED 3'b011, HIGH 3'b111.
REQ-019 scale and led SHALL change on the same edge as mode, with no glitch or intermediate value.
REQ-020 mode_chg SHALL be high for exactly the one cycle following any mode transition (press or auto-off), and low otherwise.
REQ-021 The lockout counter SHALL saturate/stop at terminal count, with no wrap or re-trigger without a new accepted press.

Reset
REQ-022 While rst_n==0: mode=MED (2), scale=3'd5, led=3'b011, mode_chg=0, busy=0, all counters cleared.
REQ-023 Reset asserted mid-lockout or mid-idle-count SHALL abort the count immediately; after deassertion the first released pulse SHALL be accepted.
REQ-024 The first clk edge after deassertion SHALL NOT produce mode_chg.

Configuration
REQ-025 Macro ASSIST_AUTO_OFF_EN SHALL compile in the auto-off timer.
REQ-026 With ASSIST_AUTO_OFF_EN: an idle counter SHALL clear whenever pedaling==1 or an accepted press occurs, and otherwise increment; on reaching IDLE_CYC with mode!=OFF, mode SHALL go to OFF (mode_chg pulses) and the counter SHALL hold cleared.
REQ-027 With ASSIST_AUTO_OFF_EN: if an accepted press and the timeout occur on the same cycle, the press SHALL win (normal advance) and the timer SHALL clear.
REQ-028 With ASSIST_AUTO_OFF_EN: in OFF the timer SHALL hold at zero; the rider leaves OFF only by a press.
REQ-029 Without ASSIST_AUTO_OFF_EN: pedaling SHALL be ignored, no idle counter logic SHALL exist, and mode changes only by press or reset.

Verification (bench: LOCKOUT_CYC=4, IDLE_CYC=16)
REQ-030 Reset, then 4 presses spaced 10 cycles apart -> mode 2,3,0,1,2; scale 5,7,0,3,5; led 011,111,000,001,011; 4 mode_chg pulses.
REQ-031 Press at cycle 0, presses at cycles 2 and 4 -> only the first is accepted; busy high for cycles 1-4; a press at cycle 5 is accepted.
REQ-032 Press at cycle 0, rst_n low at cycle 2 for 3 cycles -> mode=2, busy=0 at once; a press 1 cycle after release of reset -> mode=3.
REQ-033 AUTO_OFF_EN, pedaling=0, mode=HIGH, no press -> 16 cycles later mode=0, scale=0, led=000, single mode_chg; pedaling=1 at cycle 10 restarts the count.
REQ-034 AUTO_OFF_EN, accepted press on the timeout cycle from MED -> mode=3, no transition to OFF, timer=0.
REQ-035 Macro undefined, pedaling=0 for 100 cycles in MED -> mode stays 2, no mode_chg.

Source files
------------

// File: rtl/assist_mode_sel.sv
// ---------------------------------------------------------------------------
// assist_mode_sel
//
// Push-button assist-level selector for an e-bike drive. Each accepted
// button release advances OFF -> LOW -> MED -> HIGH -> OFF. After an accepted
// press the button is locked out for LOCKOUT_CYC clocks (debounce/anti-
// repeat). Mode, torque scale and LED bar are all registered together so
// they always change on the same edge.
//
// Optional feature (macro ASSIST_AUTO_OFF_EN): an inactivity timer drops the
// mode to OFF after IDLE_CYC clocks without pedaling or button activity.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (mode returns to MED)
//   released  in   one-clock pulse, button released (already synchronized)
//   pedaling  in   rider pedaling activity level (auto-off build only)
//   mode      out  [1:0] 0=OFF 1=LOW 2=MED 3=HIGH
//   scale     out  [2:0] torque scale: 0/3/5/7
//   led       out  [2:0] thermometer bar: 000/001/011/111
//   mode_chg  out  one-clock pulse in the cycle after any mode change
//   busy      out  high while the press lockout is running
// ---------------------------------------------------------------------------
module assist_mode_sel #(
    parameter int LOCKOUT_CYC = 1_000_000,
    parameter int IDLE_CYC    = 250_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       released,
    input  logic       pedaling,
    output logic [1:0] mode,
    output logic [2:0] scale,
    output logic [2:0] led,
    output logic       mode_chg,
    output logic       busy
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_MED  = 2'd2;
    localparam logic [1:0] ST_HIGH = 2'd3;

    // busy drops on the edge where the counter has already spent
    // LOCKOUT_CYC cycles high (counter starts at 1 on the press edge).
    localparam logic [23:0] LOCK_LAST = 24'(LOCKOUT_CYC);

    function automatic logic [2:0] scale_of(input logic [1:0] m);
        case (m)
            ST_OFF:  scale_of = 3'd0;
            ST_LOW:  scale_of = 3'd3;
            ST_MED:  scale_of = 3'd5;
            default: scale_of = 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] led_of(input logic [1:0] m);
        case (m)
            ST_OFF:  led_of = 3'b000;
            ST_LOW:  led_of = 3'b001;
            ST_MED:  led_of = 3'b011;
            default: led_of = 3'b111;
        endcase
    endfunction

    logic [1:0]  mode_reg, mode_next;
    logic [2:0]  scale_reg;
    logic [2:0]  led_reg;
    logic        mode_chg_reg, chg_next;
    logic        busy_reg;
    logic [23:0] lock_cnt_reg;
    logic        press_ok;
    logic        timeout;

    // busy is the registered flag, so a release in the cycle busy falls
    // (busy_reg already 0) is accepted.
    assign press_ok = released & ~busy_reg;

`ifdef ASSIST_AUTO_OFF_EN
    localparam logic [27:0] IDLE_LAST = 28'(IDLE_CYC - 1);

    logic [27:0] idle_cnt_reg, idle_next;

    // Fires on the edge that would bring the count to IDLE_CYC.
    assign timeout = (mode_reg != ST_OFF) && !pedaling &&
                     (idle_cnt_reg == IDLE_LAST);

    always_comb begin
        idle_next = idle_cnt_reg + 28'd1;
        // Press wins over timeout; OFF holds the timer at zero.
        if (press_ok || pedaling || timeout || mode_reg == ST_OFF)
            idle_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_reg <= '0;
        else
            idle_cnt_reg <= idle_next;
    end
`else
    logic unused_cfg;
    assign unused_cfg = pedaling ^ IDLE_CYC[0];
    assign timeout    = 1'b0;
`endif

    always_comb begin
        mode_next = mode_reg;
        chg_next  = 1'b0;
        if (press_ok) begin
            mode_next = mode_reg + 2'd1;   // HIGH wraps to OFF
            chg_next  = 1'b1;
        end else if (timeout) begin
            mode_next = ST_OFF;
            chg_next  = 1'b1;
        end
    end

    // Decodes are taken from mode_next so all three outputs move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg     <= ST_MED;
            scale_reg    <= 3'd5;
            led_reg      <= 3'b011;
            mode_chg_reg <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            scale_reg    <= scale_of(mode_next);
            led_reg      <= led_of(mode_next);
            mode_chg_reg <= chg_next;
        end
    end

    // Lockout counter: stops at terminal count and stays there until the
    // next accepted press reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= 1'b0;
            lock_cnt_reg <= '0;
        end else if (press_ok) begin
            busy_reg     <= 1'b1;
            lock_cnt_reg <= 24'd1;
        end else if (busy_reg) begin
            if (lock_cnt_reg == LOCK_LAST)
                busy_reg <= 1'b0;
            else
                lock_cnt_reg <= lock_cnt_reg + 24'd1;
        end
    end

    assign mode     = mode_reg;
    assign scale    = scale_reg;
    assign led      = led_reg;
    assign mode_chg = mode_chg_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_assist_mode_sel.sv
// ---------------------------------------------------------------------------
// tb_assist_mode_sel
//
// Directed self-checking bench for assist_mode_sel with LOCKOUT_CYC=4 and
// IDLE_CYC=16. Inputs change 1 ns after the rising edge; outputs are
// sampled at the same point, i.e. after the edge has settled.
// The auto-off scenarios are compiled in when ASSIST_AUTO_OFF_EN is defined;
// otherwise the "pedaling is ignored" scenario runs.
// ---------------------------------------------------------------------------
module tb_assist_mode_sel;

    logic       clk;
    logic       rst_n;
    logic       released;
    logic       pedaling;
    logic [1:0] mode;
    logic [2:0] scale;
    logic [2:0] led;
    logic       mode_chg;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int chg_cnt = 0;

    assist_mode_sel #(
        .LOCKOUT_CYC(4),
        .IDLE_CYC   (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .released (released),
        .pedaling (pedaling),
        .mode     (mode),
        .scale    (scale),
        .led      (led),
        .mode_chg (mode_chg),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count mode_chg pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (mode_chg === 1'b1)
            chg_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        released = 1'b1;
        tick();
        released = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] m,
                              input logic [2:0] s, input logic [2:0] l);
        check({tag, ".mode"},  32'(mode),  32'(m));
        check({tag, ".scale"}, 32'(scale), 32'(s));
        check({tag, ".led"},   32'(led),   32'(l));
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_mode [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [2:0] exp_scl  [4] = '{3'd7, 3'd0, 3'd3, 3'd5};
    logic [2:0] exp_led  [4] = '{3'b111, 3'b000, 3'b001, 3'b011};

    initial begin
        int base;
        rst_n    = 1'b0;
        released = 1'b0;
        pedaling = 1'b0;

        // ---- reset state ----
        repeat (2) tick();
        check_outs("rst", 2'd2, 3'd5, 3'b011);
        check("rst.mode_chg", 32'(mode_chg), 0);
        check("rst.busy",     32'(busy),     0);
        rst_n = 1'b1;
        tick();
        check("first_edge.mode_chg", 32'(mode_chg), 0);
        check("first_edge.mode",     32'(mode),     2);

        // ---- four presses 10 cycles apart: 3,0,1,2 ----
        base = chg_cnt;
        for (int i = 0; i < 4; i++) begin
            press();
            check_outs($sformatf("seq%0d", i), exp_mode[i], exp_scl[i], exp_led[i]);
            check($sformatf("seq%0d.busy", i),     32'(busy),     1);
            check($sformatf("seq%0d.chg_on", i),   32'(mode_chg), 1);
            tick();
            check($sformatf("seq%0d.chg_off", i),  32'(mode_chg), 0);
            repeat (8) tick();
        end
        check("seq.chg_pulses", 32'(chg_cnt - base), 4);

        // ---- lockout: press c0 accepted, c2/c4 ignored, c5 accepted ----
        released = 1'b1; tick();                 // now cycle 1
        check("lock.c1.mode", 32'(mode), 3);
        check("lock.c1.busy", 32'(busy), 1);
        released = 1'b0; tick();                 // cycle 2
        released = 1'b1; tick();                 // cycle 3
        check("lock.c3.mode", 32'(mode), 3);
        check("lock.c3.busy", 32'(busy), 1);
        released = 1'b0; tick();                 // cycle 4
        check("lock.c4.busy", 32'(busy), 1);
        released = 1'b1; tick();                 // cycle 5
        check("lock.c5.mode", 32'(mode), 3);
        check("lock.c5.busy", 32'(busy), 0);
        released = 1'b1; tick();                 // cycle 6: c5 press accepted
        released = 1'b0;
        check("lock.c6.mode", 32'(mode), 0);
        check("lock.c6.busy", 32'(busy), 1);
        repeat (5) tick();

        // ---- reset mid-lockout ----
        press();                                 // cycle 1
        check("rstlk.mode", 32'(mode), 1);
        check("rstlk.busy", 32'(busy), 1);
        tick();                                  // cycle 2
        rst_n = 1'b0;
        #1;
        check_outs("rstlk.async", 2'd2, 3'd5, 3'b011);
        check("rstlk.async.busy", 32'(busy), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rstlk.post.chg", 32'(mode_chg), 0);
        press();
        check("rstlk.press.mode", 32'(mode), 3);
        check("rstlk.press.busy", 32'(busy), 1);
        repeat (5) tick();

`ifdef ASSIST_AUTO_OFF_EN
        // ---- auto-off from HIGH after 16 idle cycles ----
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        press();                                 // MED -> HIGH, timer 0
        base = chg_cnt;
        repeat (15) tick();
        check("idle.before.mode", 32'(mode), 3);
        tick();
        check_outs("idle.off", 2'd0, 3'd0, 3'b000);
        check("idle.off.chg", 32'(mode_chg), 1);
        tick();
        check("idle.off.chg_off", 32'(mode_chg), 0);
        check("idle.chg_pulses", 32'(chg_cnt - base), 1);
        repeat (20) tick();
        check("idle.stay_off", 32'(mode), 0);

        // ---- pedaling at cycle 10 restarts the count ----
        press(); repeat (5) tick();
        press(); repeat (5) tick();
        press();                                 // into HIGH
        check("ped.mode", 32'(mode), 3);
        repeat (9) tick();                       // cycle 10
        pedaling = 1'b1; tick(); pedaling = 1'b0;
        repeat (15) tick();
        check("ped.hold.mode", 32'(mode), 3);
        tick();
        check("ped.off.mode", 32'(mode), 0);

        // ---- press on the timeout cycle from MED wins ----
        press(); repeat (5) tick();
        press();                                 // into MED, timer 0
        check("race.med", 32'(mode), 2);
        repeat (15) tick();
        press();                                 // timeout edge
        check("race.mode", 32'(mode), 3);
        check("race.chg",  32'(mode_chg), 1);
        repeat (15) tick();
        check("race.timer_cleared", 32'(mode), 3);
        tick();
        check("race.later_off", 32'(mode), 0);
`else
        // ---- no auto-off: idle 100 cycles in MED ----
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        base = chg_cnt;
        pedaling = 1'b0;
        repeat (100) tick();
        check("noauto.mode", 32'(mode), 2);
        check("noauto.chg_pulses", 32'(chg_cnt - base), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
